bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/arbiter_pkg.sv | 7 +
 rtl/arbiter_picker.sv | 28 ++
 rtl/bus_arbiter.sv | 124 ++++++++++++
 tb/tb_bus_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// arbiter_pkg: FSM state encoding and arbitration mode constants that the
// arbiter and its testbench share.
package arbiter_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_ACK} state_t;
   localparam int MODE_PRIORITY    = 0;
   localparam int MODE_ROUND_ROBIN = 1;
endpackage

// File: rtl/arbiter_picker.sv
// arbiter_picker: combinational winner select. It uses fixed priority (lowest
// index first) or round-robin, which starts at the index after the last grant.
module arbiter_picker #(
   parameter int NUM_CONTROLLERS = 3,
   parameter int IDX_W           = 2
) (
   input  logic [NUM_CONTROLLERS-1:0] i_eligible,
   input  logic [IDX_W-1:0]           i_last_grant,
   input  logic                       i_round_robin,
   output logic [IDX_W-1:0]           o_winner,
   output logic                       o_valid
);
   int w_cand;
   always_comb begin
      o_winner = '0;
      o_valid  = 1'b0;
      w_cand   = 0;
      // Candidates are scanned from lowest priority to highest, so the last hit is the winner.
      for (int i = NUM_CONTROLLERS; i >= 1; i--) begin
         w_cand = i_round_robin ? int'(i_last_grant) + i : i - 1;
         w_cand = (w_cand >= NUM_CONTROLLERS) ? w_cand - NUM_CONTROLLERS : w_cand;
         if (i_eligible[w_cand[IDX_W-1:0]]) begin
            o_winner = w_cand[IDX_W-1:0];
            o_valid  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: multiplexes several bank-addressed controllers onto one device
// port. It uses an IDLE/ISSUE/WAIT_ACK transaction FSM and an optional ack timeout.
module bus_arbiter
   import arbiter_pkg::*;
#(
   parameter int NUM_CONTROLLERS = 3,
   parameter int ADDRESS_WIDTH   = 25,
   parameter int DATA_WIDTH      = 32,
   parameter int BANK_WIDTH      = 4,
   parameter int DEVICE_BANK     = 0,
   parameter int MODE            = 0,
   parameter int TIMEOUT_CYCLES  = 0
) (
   input  logic                                  i_clk,
   input  logic                                  i_reset,
   input  logic [NUM_CONTROLLERS-1:0]            i_request,
   input  logic [NUM_CONTROLLERS-1:0]            i_write,
   output logic [NUM_CONTROLLERS-1:0]            o_busy,
   output logic [NUM_CONTROLLERS-1:0]            o_ack,
   input  logic [NUM_CONTROLLERS*BANK_WIDTH-1:0] i_bank,
   input  logic [NUM_CONTROLLERS*ADDRESS_WIDTH-1:0] i_address,
   input  logic [NUM_CONTROLLERS*DATA_WIDTH-1:0] i_data,
   output logic [NUM_CONTROLLERS*DATA_WIDTH-1:0] o_data,
   output logic                                  o_device_request,
   output logic                                  o_device_write,
   input  logic                                  i_device_busy,
   input  logic                                  i_device_ack,
   output logic [ADDRESS_WIDTH-1:0]              o_device_address,
   output logic [DATA_WIDTH-1:0]                 o_device_data,
   input  logic [DATA_WIDTH-1:0]                 i_device_data,
   output logic                                  o_timeout
);
   localparam int IDX_W = (NUM_CONTROLLERS > 1) ? $clog2(NUM_CONTROLLERS) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);

   state_t                     r_state;
   logic [IDX_W-1:0]           r_grant;
   logic [IDX_W-1:0]           r_last_grant;
   logic                       r_write;
   logic                       r_ready;
   logic [ADDRESS_WIDTH-1:0]   r_address;
   logic [DATA_WIDTH-1:0]      r_data;
   logic [CNT_W-1:0]           r_wait_cnt;
   logic [NUM_CONTROLLERS-1:0] w_eligible;
   logic [IDX_W-1:0]           w_winner;
   logic                       w_valid;
   logic                       w_issue;
   logic                       w_timeout;
   logic                       w_done;

   for (genvar k = 0; k < NUM_CONTROLLERS; k++) begin : g_elig
      assign w_eligible[k] = i_request[k] &&
         (i_bank[k*BANK_WIDTH +: BANK_WIDTH] == BANK_WIDTH'(DEVICE_BANK));
   end

   arbiter_picker #(
      .NUM_CONTROLLERS(NUM_CONTROLLERS),
      .IDX_W          (IDX_W)
   ) u_picker (
      .i_eligible   (w_eligible),
      .i_last_grant (r_last_grant),
      .i_round_robin(1'(MODE == MODE_ROUND_ROBIN)),
      .o_winner     (w_winner),
      .o_valid      (w_valid)
   );

   // If ack and timeout land in the same cycle, the ack wins.
   assign w_issue   = r_state == ST_ISSUE;
   assign w_timeout = TIMEOUT_CYCLES > 0 && r_state == ST_WAIT_ACK && !i_device_ack &&
                      int'(r_wait_cnt) == TIMEOUT_CYCLES - 1;
   assign w_done    = r_state == ST_WAIT_ACK && (i_device_ack || w_timeout);

   // r_ready holds off the first grant until the second edge after reset release.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_last_grant <= IDX_W'(NUM_CONTROLLERS - 1);
         r_write      <= 1'b0;
         r_ready      <= 1'b0;
         r_address    <= '0;
         r_data       <= '0;
         r_wait_cnt   <= '0;
      end else begin
         r_ready <= 1'b1;
         case (r_state)
            ST_IDLE: if (r_ready && w_valid) begin
               r_state      <= ST_ISSUE;
               r_grant      <= w_winner;
               r_last_grant <= w_winner;
               r_write      <= i_write[w_winner];
               r_address    <= i_address[w_winner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
               r_data       <= i_data[w_winner*DATA_WIDTH +: DATA_WIDTH];
            end
            ST_ISSUE: if (!i_device_busy) begin
               r_state    <= ST_WAIT_ACK;
               r_wait_cnt <= '0;
            end
            ST_WAIT_ACK: begin
               r_wait_cnt <= r_wait_cnt + 1'b1;
               if (w_done) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      o_busy = w_eligible & {NUM_CONTROLLERS{i_reset}};
      o_ack  = '0;
      o_data = '0;
      if (w_issue && !i_device_busy) o_busy[r_grant] = 1'b0;
      if (w_done) begin
         o_ack[r_grant] = 1'b1;
         o_data[r_grant*DATA_WIDTH +: DATA_WIDTH] = i_device_ack ? i_device_data : '1;
      end
   end

   assign o_device_request = w_issue;
   assign o_device_write   = w_issue && r_write;
   assign o_device_address = w_issue ? r_address : '0;
   assign o_device_data    = w_issue ? r_data : '0;
   assign o_timeout        = w_timeout;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: two arbiters (fixed priority and round-robin) share one set of stimulus.
// Monitors compare device-side issues and controller acks against queued expectations.
module tb_bus_arbiter;
   localparam int N = 3, AW = 25, DW = 32, BW = 4, TO = 8;

   typedef struct {
      int             ctrl;
      logic [DW-1:0]  data;
      bit             to;
      int             lat;
   } ack_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req, wr, dropped, pend, eff_req;
   logic [N*BW-1:0]   bank;
   logic [N*AW-1:0]   addr;
   logic [N*DW-1:0]   wdata;
   logic              dev_busy, dev_ack, force_ack;
   logic [DW-1:0]     dev_rdata;
   logic [N-1:0]      busy [2];
   logic [N-1:0]      ack [2];
   logic [N*DW-1:0]   rdata [2];
   logic              dreq [2], dwr [2], tout [2];
   logic [AW-1:0]     daddr [2];
   logic [DW-1:0]     ddata [2];

   int   checks = 0, fails = 0, cyc = 0;
   int   busy_cycles = 0, ack_lat = 1, total = 0;
   bit   auto_drop = 1'b1;
   int   q_iss [2][$];
   ack_t q_ack [2][$];
   int   n_ack [2], cur [2], iss_len [2], acc_cyc [2];
   bit   prev_req [2];

   assign eff_req = req & ~dropped;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      bus_arbiter #(
         .NUM_CONTROLLERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BANK_WIDTH(BW),
         .DEVICE_BANK(0), .MODE(g), .TIMEOUT_CYCLES(TO)
      ) dut (
         .i_clk(clk), .i_reset(rst_n), .i_request(eff_req), .i_write(wr),
         .o_busy(busy[g]), .o_ack(ack[g]), .i_bank(bank), .i_address(addr),
         .i_data(wdata), .o_data(rdata[g]), .o_device_request(dreq[g]),
         .o_device_write(dwr[g]), .i_device_busy(dev_busy), .i_device_ack(dev_ack),
         .o_device_address(daddr[g]), .o_device_data(ddata[g]),
         .i_device_data(dev_rdata), .o_timeout(tout[g])
      );
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input int d, input string name, input logic [N*DW-1:0] act,
                      input logic [N*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL dut%0d %s: got %0h expected %0h (cycle %0d)", d, name, act, exp, cyc);
      end
   endtask

   function automatic bit elig(input int k);
      return eff_req[k] && bank[k*BW +: BW] == '0;
   endfunction

   function automatic logic [N*DW-1:0] exp_rd(input ack_t e);
      logic [N*DW-1:0] v;
      v = '0;
      v[e.ctrl*DW +: DW] = e.data;
      return v;
   endfunction

   // Device model: holds busy for busy_cycles, acks after ack_lat wait cycles (0 = never),
   // and drops the request of whichever controller was just accepted.
   initial begin : device
      int  bcnt, wcnt;
      bit  in_wait;
      bcnt = 0; wcnt = 0; in_wait = 1'b0;
      dev_busy = 1'b0; dev_ack = 1'b0; dropped = '0; pend = '0;
      forever begin
         @(posedge clk); #1;
         dropped = (dropped | pend) & req & {N{rst_n}};
         pend = '0;
         dev_busy = 1'b0;
         dev_ack = force_ack;
         if (!rst_n) begin
            in_wait = 1'b0;
            bcnt = 0;
         end else if (dreq[1]) begin
            dev_busy = bcnt < busy_cycles;
            if (dev_busy) bcnt++;
            else begin
               in_wait = 1'b1;
               wcnt = 0;
               bcnt = 0;
            end
         end else if (in_wait) begin
            wcnt++;
            if (ack_lat > 0 && wcnt == ack_lat) dev_ack = 1'b1;
            if (dev_ack || wcnt == TO) in_wait = 1'b0;
         end
         @(negedge clk);
         if (auto_drop && dreq[1] && !dev_busy)
            for (int k = 0; k < N; k++) if (elig(k) && !busy[0][k]) pend[k] = 1'b1;
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (dreq[d]) begin
            if (!prev_req[d]) begin
               iss_len[d] = 0;
               if (q_iss[d].size() == 0) begin
                  chk(d, "unexpected_grant", 1, 0);
                  cur[d] = 0;
               end else cur[d] = q_iss[d].pop_front();
            end
            iss_len[d]++;
            chk(d, "dev_address", daddr[d], addr[cur[d]*AW +: AW]);
            chk(d, "dev_data", ddata[d], wdata[cur[d]*DW +: DW]);
            chk(d, "dev_write", dwr[d], wr[cur[d]]);
            chk(d, "busy_granted", busy[d][cur[d]], elig(cur[d]) && dev_busy);
            if (!dev_busy) begin
               chk(d, "issue_len", iss_len[d], busy_cycles + 1);
               acc_cyc[d] = cyc;
            end
         end else chk(d, "idle_dev_outputs", {dwr[d], daddr[d], ddata[d]}, '0);
         prev_req[d] = dreq[d];
         if (ack[d] != '0 || tout[d]) begin
            if (q_ack[d].size() == 0) chk(d, "unexpected_ack", {ack[d], tout[d]}, '0);
            else begin
               ack_t e;
               e = q_ack[d].pop_front();
               chk(d, "ack_onehot", ack[d], N'(1) << e.ctrl);
               chk(d, "ack_data", rdata[d], exp_rd(e));
               chk(d, "timeout_flag", tout[d], e.to);
               chk(d, "ack_latency", cyc - acc_cyc[d], e.lat);
               n_ack[d]++;
            end
         end
      end
   end

   task automatic expect_txn(input int d, input int k, input logic [DW-1:0] data,
                             input bit to, input int lat);
      ack_t e;
      e.ctrl = k; e.data = data; e.to = to; e.lat = lat;
      q_iss[d].push_back(k);
      q_ack[d].push_back(e);
   endtask

   task automatic wait_acks(input int n);
      total += n;
      for (int i = 0; i < 400 && n_ack[1] < total; i++) begin
         @(negedge clk); #2;
      end
      chk(1, "ack_wait_expired", 32'(n_ack[1] >= total), 1);
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      req = '0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs();
      for (int d = 0; d < 2; d++) begin
         chk(d, "rst_busy", busy[d], '0);
         chk(d, "rst_ack", ack[d], '0);
         chk(d, "rst_timeout", tout[d], '0);
         chk(d, "rst_rdata", rdata[d], '0);
         chk(d, "rst_dev_request", dreq[d], '0);
      end
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req = '0; wr = 3'b010; bank = '0; force_ack = 1'b0;
      dev_rdata = '0;
      for (int k = 0; k < N; k++) begin
         addr[k*AW +: AW]  = AW'(32'h1A0 + 32'h111 * k);
         wdata[k*DW +: DW] = 32'hA5A5_0000 + k;
      end
      n_ack = '{0, 0}; prev_req = '{0, 0}; cur = '{0, 0};
      repeat (3) @(negedge clk);
      chk_reset_outputs();
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Controllers 0 and 2 together: 0 first, 2 granted in the cycle after 0's ack.
      dev_rdata = 32'h1111_0001; ack_lat = 2;
      for (int d = 0; d < 2; d++) begin
         expect_txn(d, 0, dev_rdata, 0, 2);
         expect_txn(d, 2, dev_rdata, 0, 2);
      end
      req = 3'b101;
      wait_acks(1);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk(d, "idle_after_ack", dreq[d], 0);
         chk(d, "busy_waiting_ctrl2", busy[d][2], 1);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk(d, "grant_after_ack", dreq[d], 1);
      wait_acks(1);
      idle(2);

      // Continuous requests from all three, ack latency 1.
      dev_rdata = 32'h2222_0002; ack_lat = 1; auto_drop = 1'b0;
      for (int i = 0; i < 6; i++) begin
         expect_txn(0, 0, dev_rdata, 0, 1);
         expect_txn(1, i % 3, dev_rdata, 0, 1);
      end
      req = 3'b111;
      wait_acks(6);
      idle(2);

      // Device busy for 5 ISSUE cycles: acceptance happens in the 6th cycle.
      auto_drop = 1'b1; busy_cycles = 5; ack_lat = 3; dev_rdata = 32'h3333_0003;
      for (int d = 0; d < 2; d++) expect_txn(d, 2, dev_rdata, 0, 3);
      req = 3'b100;
      wait_acks(1);
      idle(2);
      busy_cycles = 0;

      // No ack: timeout in the 8th wait cycle, data all ones.
      ack_lat = 0; dev_rdata = 32'h4444_0004;
      for (int d = 0; d < 2; d++) expect_txn(d, 0, '1, 1, TO);
      req = 3'b001;
      wait_acks(1);
      idle(2);

      // Ack arrives in the 8th wait cycle: the ack wins and there is no timeout.
      ack_lat = TO;
      for (int d = 0; d < 2; d++) expect_txn(d, 0, dev_rdata, 0, TO);
      req = 3'b001;
      wait_acks(1);
      idle(2);

      // Wrong bank for controller 1: it is never busy and never granted. A stray ack is ignored.
      ack_lat = 1; dev_rdata = 32'h5555_0005;
      bank[1*BW +: BW] = 4'h3;
      req = 3'b010;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #2;
         force_ack = (i == 3);
         for (int d = 0; d < 2; d++) begin
            chk(d, "foreign_bank_busy", busy[d][1], 0);
            chk(d, "foreign_bank_request", dreq[d], 0);
         end
      end
      force_ack = 1'b0;
      for (int d = 0; d < 2; d++) expect_txn(d, 0, dev_rdata, 0, 1);
      @(posedge clk); #1;
      req = 3'b011;
      wait_acks(1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) chk(d, "foreign_bank_no_grant", dreq[d], 0);
      end
      idle(2);
      bank = '0;

      // Reset during WAIT_ACK: no ack, outputs cleared, round-robin restarts at 0.
      ack_lat = 0;
      for (int d = 0; d < 2; d++) q_iss[d].push_back(0);
      req = 3'b001;
      for (int i = 0; i < 50 && !dreq[1]; i++) @(negedge clk);
      for (int i = 0; i < 50 && dreq[1]; i++) @(negedge clk);
      @(negedge clk); #2;
      rst_n = 1'b0;
      req = 3'b011;
      @(negedge clk);
      chk_reset_outputs();
      @(negedge clk);
      chk_reset_outputs();
      dev_rdata = 32'h6666_0006; ack_lat = 1;
      for (int d = 0; d < 2; d++) begin
         expect_txn(d, 0, dev_rdata, 0, 1);
         expect_txn(d, 1, dev_rdata, 0, 1);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk(d, "no_grant_first_edge", dreq[d], 0);
      wait_acks(2);
      idle(4);

      for (int d = 0; d < 2; d++) begin
         chk(d, "pending_issues", q_iss[d].size(), 0);
         chk(d, "pending_acks", q_ack[d].size(), 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
